// File: rtl/bist_analyzer_pkg.sv
// Shared constants and types for the BIST response analyzer.
// Holds state encoding, default polynomials and the golden pattern count.
package bist_analyzer_pkg;

    localparam int N_MAX = 8;
    localparam int M_MAX = 9;
    localparam int EXP_PATTERNS_DEF = N_MAX * (M_MAX + 1);

    localparam logic [7:0] LFSR_POLY_DEF = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'h01;
    localparam logic [7:0] MISR_POLY_DEF = 8'hB8;
    localparam logic [7:0] GOLDEN_SIG_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic done;
        logic pass;
        logic fail;
        logic aborted;
    } verdict_t;

endpackage

// File: rtl/bist_analyzer_if.sv
// Controller-side and CUT-side signals of the BIST analyzer.
// master drives the controller flags and CUT response; slave is the analyzer.
interface bist_analyzer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);

    logic             running;
    logic             test_en;
    logic             bist_end;
    logic [WIDTH-1:0] cut_resp;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] pat_count;
    logic             done;
    logic             pass;
    logic             fail;
    logic             aborted;

    modport master (
        output running, test_en, bist_end, cut_resp,
        input  pattern, signature, pat_count,
        input  done, pass, fail, aborted
    );

    modport slave (
        input  running, test_en, bist_end, cut_resp,
        output pattern, signature, pat_count,
        output done, pass, fail, aborted
    );

endinterface

// File: rtl/bist_analyzer_lfsr_galois.sv
// Galois shift register with seed load and XOR data input.
// Right shift serves as pattern LFSR; left shift with data_i serves as MISR.
module lfsr_galois #(
    parameter int WIDTH        = 8,
    parameter bit SHIFT_LEFT   = 1'b0,
    parameter bit NONZERO_SEED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] poly_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH-1:0] base;

    // A zero seed would lock a pure LFSR at zero forever.
    always_comb begin
        seed_eff = seed_i;
        if (NONZERO_SEED && (seed_i == '0)) begin
            seed_eff = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        base    = load_i ? seed_eff : value_q;
        value_d = base;
        if (enable_i) begin
            if (SHIFT_LEFT) begin
                value_d = {base[WIDTH-2:0], 1'b0}
                        ^ (base[WIDTH-1] ? poly_i : '0)
                        ^ data_i;
            end else begin
                value_d = (base >> 1)
                        ^ (base[0] ? poly_i : '0)
                        ^ data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= seed_eff;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/bist_analyzer.sv
// BIST analyzer: LFSR pattern source, MISR compactor and pass/fail verdict.
// Follows the controller's running / test_en / bist_end handshake.
module bist_analyzer
    import bist_analyzer_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] LFSR_POLY    = WIDTH'(LFSR_POLY_DEF),
    parameter logic [WIDTH-1:0] LFSR_SEED    = WIDTH'(LFSR_SEED_DEF),
    parameter logic [WIDTH-1:0] MISR_POLY    = WIDTH'(MISR_POLY_DEF),
    parameter logic [WIDTH-1:0] GOLDEN_SIG   = WIDTH'(GOLDEN_SIG_DEF),
    parameter int               EXP_PATTERNS = EXP_PATTERNS_DEF,
    parameter int               CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    bist_analyzer_if.slave   bus
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    verdict_t         flags_q;
    verdict_t         flags_d;

    logic             lfsr_load;
    logic             lfsr_en;
    logic             misr_load;
    logic             misr_en;
    logic             verdict_ok;
    logic [WIDTH-1:0] lfsr_val;
    logic [WIDTH-1:0] misr_val;

    assign verdict_ok = (misr_val == GOLDEN_SIG)
                     && (cnt_q == CNT_W'(EXP_PATTERNS));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                lfsr_load = 1'b1;
                // Start edge also captures, so a run loses no first pattern.
                if (bus.running) begin
                    state_d   = CAPTURE;
                    flags_d   = '0;
                    misr_load = 1'b1;
                    lfsr_en   = bus.test_en;
                    misr_en   = bus.test_en;
                    cnt_d     = bus.test_en ? CNT_W'(1) : '0;
                end
            end
            CAPTURE: begin
                if (bus.bist_end) begin
                    state_d   = CHECK;
                    lfsr_load = 1'b1;
                end else if (!bus.running) begin
                    state_d   = DONE;
                    lfsr_load = 1'b1;
                    flags_d   = '{done: 1'b1, pass: 1'b0,
                                  fail: 1'b1, aborted: 1'b1};
                end else if (bus.test_en) begin
                    lfsr_en = 1'b1;
                    misr_en = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d   = DONE;
                lfsr_load = 1'b1;
                flags_d   = '{done: 1'b1, pass: verdict_ok,
                              fail: !verdict_ok, aborted: 1'b0};
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    lfsr_galois #(
        .WIDTH        (WIDTH),
        .SHIFT_LEFT   (1'b0),
        .NONZERO_SEED (1'b1)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (lfsr_load),
        .enable_i (lfsr_en),
        .seed_i   (LFSR_SEED),
        .poly_i   (LFSR_POLY),
        .data_i   ('0),
        .value_o  (lfsr_val)
    );

    lfsr_galois #(
        .WIDTH        (WIDTH),
        .SHIFT_LEFT   (1'b1),
        .NONZERO_SEED (1'b0)
    ) u_misr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (misr_load),
        .enable_i (misr_en),
        .seed_i   ('0),
        .poly_i   (MISR_POLY),
        .data_i   (bus.cut_resp),
        .value_o  (misr_val)
    );

    assign bus.pattern   = lfsr_val;
    assign bus.signature = misr_val;
    assign bus.pat_count = cnt_q;
    assign bus.done      = flags_q.done;
    assign bus.pass      = flags_q.pass;
    assign bus.fail      = flags_q.fail;
    assign bus.aborted   = flags_q.aborted;

endmodule

// File: tb/tb_bist_analyzer.sv
// Randomised scoreboard bench for bist_analyzer.
// Expected state is derived from the capture history of each run.
module tb_bist_analyzer;

    localparam logic [7:0] SEED  = 8'h01;
    localparam logic [7:0] POLY  = 8'hB8;
    localparam logic [7:0] MPOLY = 8'hB8;
    localparam logic [7:0] GOLD  = 8'h00;
    localparam int         EXP   = 80;

    logic clk = 1'b0;
    logic reset;
    always #50 clk = ~clk;

    bist_analyzer_if #(.WIDTH(8), .CNT_W(8)) bus ();

    bist_analyzer #(
        .WIDTH        (8),
        .LFSR_POLY    (POLY),
        .LFSR_SEED    (SEED),
        .MISR_POLY    (MPOLY),
        .GOLDEN_SIG   (GOLD),
        .EXP_PATTERNS (EXP),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] pat;
        logic [7:0] sig;
        logic [7:0] cnt;
        bit         done;
        bit         pass;
        bit         fail;
        bit         ab;
        string      tag;
    } snap_t;

    typedef struct {
        logic [7:0] sig;
        logic [7:0] cnt;
        bit         pass;
        bit         fail;
        bit         ab;
        string      tag;
    } verd_t;

    snap_t snap_q[$];
    verd_t verd_q[$];
    int    checks = 0;
    int    errors = 0;

    // reference model: history of captured responses in the current run
    int         ncap = 0;
    logic [7:0] hist[$];
    bit         m_done, m_pass, m_fail, m_ab;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_n(int n);
        logic [7:0] v = SEED;
        for (int i = 0; i < n; i++) begin
            v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        end
        return v;
    endfunction

    function automatic logic [7:0] misr_of();
        logic [7:0] s = 8'h00;
        foreach (hist[i]) begin
            s = {s[6:0], 1'b0} ^ (s[7] ? MPOLY : 8'h00) ^ hist[i];
        end
        return s;
    endfunction

    function automatic logic [7:0] sat(int n);
        return (n > 255) ? 8'hFF : 8'(n);
    endfunction

    // monitor: compares snapshots, invariants and verdicts
    bit    prev_done = 1'b0;
    snap_t s;
    verd_t v;
    always @(negedge clk) begin
        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            chk({s.tag, ".pattern"}, bus.pattern, s.pat);
            chk({s.tag, ".signature"}, bus.signature, s.sig);
            chk({s.tag, ".pat_count"}, bus.pat_count, s.cnt);
            chk({s.tag, ".flags"},
                {bus.done, bus.pass, bus.fail, bus.aborted},
                {s.done, s.pass, s.fail, s.ab});
        end
        chk("pass_fail_exclusive", bus.pass & bus.fail, 0);
        if (bus.done !== 1'b1) begin
            chk("no_verdict_when_not_done", bus.pass | bus.fail, 0);
        end
        if (bus.done === 1'b1 && !prev_done) begin
            if (verd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                v = verd_q.pop_front();
                chk({v.tag, ".v_sig"}, bus.signature, v.sig);
                chk({v.tag, ".v_cnt"}, bus.pat_count, v.cnt);
                chk({v.tag, ".v_pfa"}, {bus.pass, bus.fail, bus.aborted},
                    {v.pass, v.fail, v.ab});
            end
        end
        prev_done = (bus.done === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_snap(string tag, logic [7:0] pat);
        snap_q.push_back('{pat: pat, sig: misr_of(), cnt: sat(ncap),
                           done: m_done, pass: m_pass, fail: m_fail,
                           ab: m_ab, tag: tag});
    endtask

    task automatic start_run();
        ncap = 0;
        hist.delete();
        {m_done, m_pass, m_fail, m_ab} = 4'b0000;
    endtask

    task automatic cap(bit te, logic [7:0] resp, string tag,
                       bit use_pat = 1'b0, logic [7:0] pat = 8'h00);
        bus.running  = 1'b1;
        bus.test_en  = te;
        bus.bist_end = 1'b0;
        bus.cut_resp = resp;
        tick();
        if (te) begin
            ncap++;
            hist.push_back(resp);
        end
        push_snap(tag, use_pat ? pat : lfsr_n(ncap));
    endtask

    task automatic idle(string tag);
        bus.running  = 1'b0;
        bus.test_en  = 1'($urandom);
        bus.bist_end = 1'b0;
        bus.cut_resp = 8'($urandom);
        tick();
        push_snap(tag, SEED);
    endtask

    task automatic end_normal(bit drop, string tag);
        bit ok;
        ok = (misr_of() == GOLD) && (sat(ncap) == 8'(EXP));
        verd_q.push_back('{sig: misr_of(), cnt: sat(ncap), pass: ok,
                           fail: !ok, ab: 1'b0, tag: tag});
        bus.running  = !drop;
        bus.bist_end = 1'b1;
        bus.test_en  = 1'($urandom);
        bus.cut_resp = 8'($urandom);
        tick();
        push_snap({tag, ".check"}, SEED);
        bus.running  = 1'b0;
        bus.bist_end = 1'b0;
        bus.test_en  = 1'b0;
        tick();
        {m_done, m_pass, m_fail, m_ab} = {1'b1, ok, !ok, 1'b0};
        push_snap({tag, ".verdict"}, SEED);
        idle({tag, ".hold"});
    endtask

    task automatic abort_run(string tag);
        verd_q.push_back('{sig: misr_of(), cnt: sat(ncap), pass: 1'b0,
                           fail: 1'b1, ab: 1'b1, tag: tag});
        bus.running  = 1'b0;
        bus.bist_end = 1'b0;
        bus.test_en  = 1'($urandom);
        bus.cut_resp = 8'($urandom);
        tick();
        {m_done, m_pass, m_fail, m_ab} = 4'b1011;
        push_snap({tag, ".abort"}, SEED);
        idle({tag, ".hold"});
    endtask

    task automatic do_reset(string tag);
        reset        = 1'b1;
        bus.running  = 1'b1;
        bus.test_en  = 1'b1;
        bus.cut_resp = 8'hA5;
        tick();
        start_run();
        push_snap({tag, ".in_reset"}, SEED);
        reset = 1'b0;
        idle({tag, ".after_reset"});
    endtask

    task automatic bursts(int nb, int err_idx, string tag);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 8; k++) begin
                cap(1'b1, (ncap + 1 == err_idx) ? 8'h01 : 8'h00, tag);
            end
            if (b < nb - 1) begin
                cap(1'b0, 8'($urandom), tag);
            end
        end
    endtask

    logic [7:0] seq [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

    initial begin
        bus.running  = 1'b0;
        bus.test_en  = 1'b0;
        bus.bist_end = 1'b0;
        bus.cut_resp = 8'h00;
        reset        = 1'b1;
        tick();
        do_reset("reset");

        // known pattern sequence from seed 01
        start_run();
        for (int i = 1; i <= 5; i++) begin
            cap(1'b1, 8'($urandom), "seq", 1'b1, seq[i]);
        end
        end_normal(1'b0, "seq_end");

        start_run();
        bursts(10, 0, "golden");
        end_normal(1'b0, "golden");

        start_run();
        bursts(10, 37, "err37");
        end_normal(1'b0, "err37");

        start_run();
        bursts(9, 0, "short");
        end_normal(1'b0, "short");

        start_run();
        for (int i = 0; i < 20; i++) cap(1'b1, 8'h00, "abort20");
        abort_run("abort20");
        start_run();
        bursts(10, 0, "restart");
        end_normal(1'b0, "restart");

        start_run();
        for (int i = 0; i < 40; i++) cap(1'b1, 8'h00, "mid_reset");
        do_reset("mid_reset");
        start_run();
        bursts(10, 0, "drop_end");
        end_normal(1'b1, "drop_end");

        start_run();
        for (int i = 0; i < 260; i++) cap(1'b1, 8'($urandom), "saturate");
        end_normal(1'b0, "saturate");

        for (int r = 0; r < 6; r++) begin
            int len;
            int mode;
            len  = int'($urandom_range(1, 200));
            mode = int'($urandom_range(0, 2));
            start_run();
            for (int i = 0; i < len; i++) begin
                cap($urandom_range(0, 3) != 0, 8'($urandom), "rand");
            end
            if (mode == 2) abort_run("rand");
            else end_normal(mode == 1, "rand");
            if ($urandom_range(0, 1) == 1) idle("rand_idle");
        end

        idle("final");
        @(negedge clk);
        #1;
        checks++;
        if (verd_q.size() != 0 || snap_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d verdicts %0d snapshots pending expected 0",
                     verd_q.size(), snap_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
